// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, memory byte port and stalls.
// slave = arbiter side, master = pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_rw;
  logic              d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_we, mem_wdata,
           stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready, mem_addr, mem_we, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data port arbiter onto a byte-wide memory; words move as 4 big-endian beats.
// Optional MEM_ARB_ALIGN_CHK_EN: misaligned data word accesses skip memory and return DEAD_BEEF.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic       FETCH = 1'b0;
  localparam logic       DATA  = 1'b1;

  logic [1:0]        state;
  logic [1:0]        beat;
  logic              last_grant;
  logic              port;
  logic              rw;
  logic              size;
  logic              misal;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] shift;
  logic              if_ready_q, d_ready_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic       pick_d, grant, last_beat, chk_misal;
  logic [7:0] wbyte;

  // The ready cycle also blocks a grant so a requester still holding req
  // while it sees ready is not served a second time.
  assign grant     = ~(if_ready_q | d_ready_q) & (bus.if_req | bus.d_req);
  assign pick_d    = bus.d_req & (~bus.if_req | (last_grant == FETCH));
  assign last_beat = size ? (beat == 2'd0) : (beat == 2'd3);

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign chk_misal = pick_d & ~bus.d_size & (bus.d_addr[1:0] != 2'b00);
`else
  assign chk_misal = 1'b0;
`endif

  always_comb begin
    wbyte = wdata[7:0];
    if (!size) begin
      case (beat)
        2'd0:    wbyte = wdata[31:24];
        2'd1:    wbyte = wdata[23:16];
        2'd2:    wbyte = wdata[15:8];
        default: wbyte = wdata[7:0];
      endcase
    end
  end

  assign bus.mem_addr  = (state == XFER) ? base + ADDR_W'(beat) : '0;
  assign bus.mem_we    = (state == XFER) & rw;
  assign bus.mem_wdata = ((state == XFER) & rw) ? wbyte : 8'h00;

  assign bus.if_ready  = if_ready_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.d_req & ~d_ready_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      beat       <= 2'd0;
      last_grant <= FETCH;
      port       <= FETCH;
      rw         <= 1'b0;
      size       <= 1'b0;
      misal      <= 1'b0;
      base       <= '0;
      wdata      <= '0;
      shift      <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state)
        IDLE: if (grant) begin
          port       <= pick_d ? DATA : FETCH;
          last_grant <= pick_d ? DATA : FETCH;
          base       <= pick_d ? bus.d_addr : bus.if_addr;
          rw         <= pick_d & bus.d_rw;
          size       <= pick_d & bus.d_size;
          wdata      <= bus.d_wdata;
          shift      <= '0;
          beat       <= 2'd0;
          misal      <= chk_misal;
          state      <= chk_misal ? RESP : XFER;
        end
        XFER: begin
          if (!rw) shift <= {shift[DATA_W-9:0], bus.mem_rdata};
          if (last_beat) state <= RESP;
          else           beat  <= beat + 2'd1;
        end
        RESP: begin
          state <= IDLE;
          if (port == DATA) begin
            d_ready_q <= 1'b1;
            d_rdata_q <= rw ? '0 : (misal ? 32'hDEAD_BEEF : shift);
          end else begin
            if_ready_q <= 1'b1;
            if_rdata_q <= shift;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 256-byte memory.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr, bd_data;
  always @(posedge clk)
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int start; int lat; } exp_t;
  exp_t fq[$], dq[$];
  int n_chk = 0, n_pass = 0, nsf = 0, nsd = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic push(input bit dp, input logic [31:0] d, input int lat);
    exp_t e;
    e.data = d; e.start = cyc; e.lat = lat;
    if (dp) dq.push_back(e); else fq.push_back(e);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [31:0] d, input int lat);
    bus.if_req = 1'b1; bus.if_addr = a;
    push(1'b0, d, lat);
  endtask

  task automatic dacc(input logic rw, input logic sz, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] d, input int lat);
    bus.d_req = 1'b1; bus.d_rw = rw; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
    push(1'b1, d, lat);
  endtask

  // Pops expectations on each ready pulse and releases that port's req.
  task automatic drain(input string tag);
    exp_t e;
    nsf = 0; nsd = 0;
    for (int i = 0; i < 60 && (fq.size() > 0 || dq.size() > 0); i++) begin
      @(negedge clk);
      if (bus.stall_if)  nsf++;
      if (bus.stall_mem) nsd++;
      if (bus.if_ready) begin
        chk({tag, "_if_pending"}, 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) begin
          e = fq.pop_front();
          chk({tag, "_if_data"}, bus.if_rdata, e.data);
          chk({tag, "_if_lat"}, cyc - e.start, e.lat);
        end
        bus.if_req = 1'b0;
      end
      if (bus.d_ready) begin
        chk({tag, "_d_pending"}, 32'(dq.size() > 0), 32'd1);
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk({tag, "_d_data"}, bus.d_rdata, e.data);
          chk({tag, "_d_lat"}, cyc - e.start, e.lat);
        end
        bus.d_req = 1'b0;
      end
    end
    chk({tag, "_outstanding"}, 32'(fq.size() + dq.size()), 32'd0);
    fq.delete(); dq.delete();
    step();
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_rw = 0; bus.d_size = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bd_we = 0; bd_addr = 0; bd_data = 0;
    #1 reset = 1'b0;
    repeat (2) step();
    chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_stall", 32'({bus.stall_if, bus.stall_mem}), 32'd0);
    reset = 1'b1;
    step();

    poke(8'h00, 8'hE3); poke(8'h01, 8'hA0); poke(8'h02, 8'h10); poke(8'h03, 8'h05);
    fetch(8'h00, 32'hE3A0_1005, 6);
    drain("fetch");
    chk("fetch_stall_cycles", nsf, 6);

    dacc(1'b1, 1'b0, 8'h20, 32'h1122_3344, 32'h0, 6);
    drain("wr_word");
    chk("wr_mem20", 32'(mem[8'h20]), 32'h11);
    chk("wr_mem21", 32'(mem[8'h21]), 32'h22);
    chk("wr_mem22", 32'(mem[8'h22]), 32'h33);
    chk("wr_mem23", 32'(mem[8'h23]), 32'h44);

    poke(8'h25, 8'hAB);
    dacc(1'b0, 1'b1, 8'h25, 32'hFFFF_FFFF, 32'h0000_00AB, 3);
    drain("rd_byte");

    // last grant FETCH: data first, fetch 7 cycles behind
    fetch(8'h00, 32'hE3A0_1005, 6);
    drain("pre_fetch");
    dacc(1'b0, 1'b0, 8'h20, 32'h0, 32'h1122_3344, 6);
    fetch(8'h00, 32'hE3A0_1005, 13);
    drain("cont_lgf");
    chk("cont_lgf_stall_if", nsf, 13);

    // last grant DATA: fetch first
    dacc(1'b0, 1'b1, 8'h25, 32'h0, 32'h0000_00AB, 3);
    drain("pre_data");
    fetch(8'h00, 32'hE3A0_1005, 6);
    dacc(1'b0, 1'b0, 8'h20, 32'h0, 32'h1122_3344, 13);
    drain("cont_lgd");

    poke(8'hFE, 8'hC0); poke(8'hFF, 8'hDE); poke(8'h00, 8'h12); poke(8'h01, 8'h34);
`ifdef MEM_ARB_ALIGN_CHK_EN
    dacc(1'b0, 1'b0, 8'hFE, 32'h0, 32'hDEAD_BEEF, 2);
`else
    dacc(1'b0, 1'b0, 8'hFE, 32'h0, 32'hC0DE_1234, 6);
`endif
    drain("wrap");

    // abort a word write after two beats have landed
    poke(8'h10, 8'h00); poke(8'h11, 8'h00); poke(8'h12, 8'h00); poke(8'h13, 8'h00);
    bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_size = 1'b0; bus.d_addr = 8'h10;
    bus.d_wdata = 32'hA1B2_C3D4;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_we_active", 32'(bus.mem_we), 32'd1);
    chk("abort_addr_active", 32'(bus.mem_addr), 32'h12);
    reset = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    chk("abort_ready", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    chk("abort_d_rdata", bus.d_rdata, 32'd0);
    chk("abort_if_rdata", bus.if_rdata, 32'd0);
    step();
    reset = 1'b1;
    chk("abort_mem10", 32'(mem[8'h10]), 32'hA1);
    chk("abort_mem11", 32'(mem[8'h11]), 32'hB2);
    chk("abort_mem12", 32'(mem[8'h12]), 32'h00);
    dacc(1'b0, 1'b1, 8'h25, 32'h0, 32'h0000_00AB, 3);
    drain("post_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
